// File: rtl/vector_ctrl_pkg.sv
// Shared definitions for the vector register file instruction sequencer:
// opcodes, FSM state encoding and ALU operation codes.
package vector_ctrl_pkg;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_STORE = 3'b010;
  localparam logic [2:0] OP_ADD   = 3'b011;
  localparam logic [2:0] OP_MUL   = 3'b100;
  localparam logic [2:0] OP_RSET  = 3'b101;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_MUL = 2'b01;

  typedef enum logic [3:0] {
    S_IDLE, S_DECODE, S_MEM_RD, S_LD_WB, S_ST_RF, S_MEM_WR,
    S_RD_OPS, S_EXEC, S_WB, S_RSET, S_DONE, S_ERR
  } state_e;

  // States that wait on an external ack and are guarded by the timer.
  function automatic logic is_wait(state_e s);
    return (s == S_MEM_RD) || (s == S_MEM_WR) || (s == S_EXEC);
  endfunction

endpackage

// File: rtl/vector_wait_timer.sv
// Wait-state watchdog: held at zero outside wait states, counts each wait
// cycle and flags the last permitted cycle (count == TIMEOUT-1).
module vector_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  assign expired_o = (cnt_q == CW'(TIMEOUT - 1));

  // Counter: clear has priority; saturate at the expiry value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  cnt_q <= '0;
    else if (clr_i)              cnt_q <= '0;
    else if (en_i && !expired_o) cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: rtl/vector_controller.sv
// Instruction sequencer for the 4 x 512-bit vector register file. Takes one
// instruction at a time, drives the register file strobes plus the memory and
// ALU handshakes, and pulses done or error at the end. All outputs are
// registered from the next state so they line up with the state they belong to.
module vector_controller
  import vector_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [1:0]        instr_reg,
  input  logic [ADDR_W-1:0] instr_addr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  output logic              alu_start,
  output logic [1:0]        alu_op,
  input  logic              alu_done,
  output logic              rf_load,
  output logic              rf_store,
  output logic              rf_write_enable,
  output logic              rf_read,
  output logic              rf_random_set,
  output logic [1:0]        rf_load_addr_reg,
  output logic [1:0]        rf_store_addr_reg,
  output logic              busy,
  output logic              done,
  output logic              error
);

  state_e     state_q, state_d;
  logic [2:0] op_q;
  logic [1:0] reg_q;
  logic       tmr_exp;
  logic       accept;

  assign accept = (state_q == S_IDLE) && instr_valid && instr_ready;

  vector_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (!is_wait(state_q)),
    .en_i      (is_wait(state_q)),
    .expired_o (tmr_exp)
  );

  // Next-state routing; an ack in the expiry cycle takes the normal path.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = S_DECODE;
      S_DECODE: begin
        case (op_q)
          OP_NOP:         state_d = S_DONE;
          OP_LOAD:        state_d = S_MEM_RD;
          OP_STORE:       state_d = S_ST_RF;
          OP_ADD, OP_MUL: state_d = S_RD_OPS;
          OP_RSET:        state_d = S_RSET;
          default:        state_d = S_ERR;
        endcase
      end
      S_MEM_RD: if (mem_ack) state_d = S_LD_WB; else if (tmr_exp) state_d = S_ERR;
      S_LD_WB:  state_d = S_DONE;
      S_ST_RF:  state_d = S_MEM_WR;
      S_MEM_WR: if (mem_ack) state_d = S_DONE; else if (tmr_exp) state_d = S_ERR;
      S_RD_OPS: state_d = S_EXEC;
      S_EXEC:   if (alu_done) state_d = S_WB; else if (tmr_exp) state_d = S_ERR;
      S_WB:     state_d = S_DONE;
      S_RSET:   state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      S_ERR:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State, instruction latch and registered outputs derived from state_d.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q           <= S_IDLE;
      op_q              <= OP_NOP;
      reg_q             <= '0;
      mem_addr          <= '0;
      instr_ready       <= 1'b0;
      busy              <= 1'b0;
      mem_req           <= 1'b0;
      mem_we            <= 1'b0;
      alu_start         <= 1'b0;
      alu_op            <= ALU_ADD;
      rf_load           <= 1'b0;
      rf_store          <= 1'b0;
      rf_write_enable   <= 1'b0;
      rf_read           <= 1'b0;
      rf_random_set     <= 1'b0;
      rf_load_addr_reg  <= '0;
      rf_store_addr_reg <= '0;
      done              <= 1'b0;
      error             <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q     <= instr_op;
        reg_q    <= instr_reg;
        mem_addr <= instr_addr;
      end
      instr_ready       <= (state_d == S_IDLE);
      busy              <= (state_d != S_IDLE);
      mem_req           <= (state_d == S_MEM_RD) || (state_d == S_MEM_WR);
      mem_we            <= (state_d == S_MEM_WR);
      alu_start         <= (state_d == S_EXEC) && (state_q != S_EXEC);
      alu_op            <= (state_d == S_EXEC && !op_q[0]) ? ALU_MUL : ALU_ADD;
      rf_load           <= (state_d == S_LD_WB);
      // rf_store spans MEM_WR so the register file keeps store data stable.
      rf_store          <= (state_d == S_ST_RF) || (state_d == S_MEM_WR);
      rf_write_enable   <= (state_d == S_WB);
      rf_read           <= (state_d == S_RD_OPS);
      rf_random_set     <= (state_d == S_RSET);
      rf_load_addr_reg  <= (state_d == S_LD_WB || state_d == S_WB) ? reg_q : 2'b00;
      rf_store_addr_reg <= (state_d == S_ST_RF || state_d == S_MEM_WR) ? reg_q : 2'b00;
      done              <= (state_d == S_DONE);
      error             <= (state_d == S_ERR);
    end
  end

endmodule

// File: tb/tb_vector_controller.sv
// Directed bench for vector_controller: each instruction is issued once and a
// per-cycle monitor tallies strobes and records the done/error cycle, counted
// with the accept cycle as cycle 0.
module tb_vector_controller;

  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              instr_valid = 1'b0;
  logic              instr_ready;
  logic [2:0]        instr_op = 3'b000;
  logic [1:0]        instr_reg = 2'b00;
  logic [ADDR_W-1:0] instr_addr = '0;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack = 1'b0;
  logic              alu_start;
  logic [1:0]        alu_op;
  logic              alu_done = 1'b0;
  logic              rf_load, rf_store, rf_write_enable, rf_read, rf_random_set;
  logic [1:0]        rf_load_addr_reg, rf_store_addr_reg;
  logic              busy, done, error;

  always #5 clk = ~clk;

  vector_controller #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk               (clk),
    .reset             (reset),
    .instr_valid       (instr_valid),
    .instr_ready       (instr_ready),
    .instr_op          (instr_op),
    .instr_reg         (instr_reg),
    .instr_addr        (instr_addr),
    .mem_req           (mem_req),
    .mem_we            (mem_we),
    .mem_addr          (mem_addr),
    .mem_ack           (mem_ack),
    .alu_start         (alu_start),
    .alu_op            (alu_op),
    .alu_done          (alu_done),
    .rf_load           (rf_load),
    .rf_store          (rf_store),
    .rf_write_enable   (rf_write_enable),
    .rf_read           (rf_read),
    .rf_random_set     (rf_random_set),
    .rf_load_addr_reg  (rf_load_addr_reg),
    .rf_store_addr_reg (rf_store_addr_reg),
    .busy              (busy),
    .done              (done),
    .error             (error)
  );

  logic [33:0] all_o;
  assign all_o = {instr_ready, busy, mem_req, mem_we, alu_start, alu_op, rf_load,
                  rf_store, rf_write_enable, rf_read, rf_random_set,
                  rf_load_addr_reg, rf_store_addr_reg, done, error, mem_addr};

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor results of the last run
  int c_ld, c_st, c_rd, c_we, c_rs, c_req, c_mwe, c_as, c_rdy;
  int c_multi = 0;
  int c_ovl = 0;
  int done_cyc, err_cyc;
  logic [1:0]  ld_reg, wb_reg, st_reg, op_s;
  logic [15:0] req_addr;

  // Issue one instruction from IDLE, answer mem/alu after the given number
  // of wait cycles (0 = never), stop at done/error, then check return to IDLE.
  task automatic run(input string name, input logic [2:0] op, input logic [1:0] r,
                     input logic [15:0] a, input int mem_dly, input int alu_dly,
                     input bit hold);
    int mk, ak;
    c_ld = 0; c_st = 0; c_rd = 0; c_we = 0; c_rs = 0; c_req = 0; c_mwe = 0;
    c_as = 0; c_rdy = 0; done_cyc = 0; err_cyc = 0;
    ld_reg = 2'bxx; wb_reg = 2'bxx; st_reg = 2'bxx; op_s = 2'bxx; req_addr = 'x;
    mk = 0; ak = 0;
    instr_valid = 1'b1; instr_op = op; instr_reg = r; instr_addr = a;
    tick();
    if (hold) begin
      // Keep valid high with a different instruction; it must be ignored.
      instr_op = 3'b101; instr_reg = ~r; instr_addr = 16'hDEAD;
    end else begin
      instr_valid = 1'b0;
    end
    for (int cyc = 1; cyc <= 60; cyc++) begin
      if (mem_req) begin c_req++; mk++; req_addr = mem_addr; end
      if (mem_we) c_mwe++;
      if (rf_load) begin c_ld++; ld_reg = rf_load_addr_reg; end
      if (rf_write_enable) begin c_we++; wb_reg = rf_load_addr_reg; end
      if (rf_store) begin c_st++; st_reg = rf_store_addr_reg; end
      if (rf_read) c_rd++;
      if (rf_random_set) c_rs++;
      if (alu_start) begin c_as++; op_s = alu_op; ak = 1; end
      else if (ak > 0) ak++;
      if (instr_ready) c_rdy++;
      if (int'(rf_load) + int'(rf_write_enable) + int'(rf_read) + int'(rf_random_set) > 1)
        c_multi++;
      if (rf_store && mem_req && !mem_we) c_ovl++;
      mem_ack  = mem_req && (mk == mem_dly);
      alu_done = (ak > 0) && (ak == alu_dly);
      if (done)  done_cyc = cyc;
      if (error) err_cyc = cyc;
      if (done || error) break;
      tick();
    end
    mem_ack = 1'b0; alu_done = 1'b0; instr_valid = 1'b0;
    tick();
    chk({name, "_idle"}, {instr_ready, busy, done, error}, 4'b1000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held 3 cycles: every output low
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_outs", all_o, '0);
    end
    reset = 1'b1;
    chk("rel_pre_ready", instr_ready, 1'b0);
    tick();
    chk("rel_ready", {instr_ready, busy}, 2'b10);

    run("nop", 3'b000, 2'd0, 16'h0000, 0, 0, 1'b0);
    chk("nop_done_cyc", done_cyc, 2);
    chk("nop_no_err", err_cyc, 0);

    run("rset", 3'b101, 2'd2, 16'h0000, 0, 0, 1'b0);
    chk("rset_done_cyc", done_cyc, 3);
    chk("rset_cnt", c_rs, 1);
    chk("rset_others", c_ld + c_st + c_we + c_rd + c_req, 0);

    run("store", 3'b010, 2'd2, 16'h0010, 1, 0, 1'b0);
    chk("st_rf_store_cyc", c_st, 2);
    chk("st_req_cyc", c_req, 1);
    chk("st_we_cyc", c_mwe, 1);
    chk("st_reg", st_reg, 2'd2);
    chk("st_addr", req_addr, 16'h0010);
    chk("st_done_cyc", done_cyc, 4);
    chk("st_no_load", c_ld, 0);

    run("load", 3'b001, 2'd1, 16'h00FF, 4, 0, 1'b1);
    chk("ld_req_cyc", c_req, 4);
    chk("ld_we_cyc", c_mwe, 0);
    chk("ld_strobe", c_ld, 1);
    chk("ld_reg", ld_reg, 2'd1);
    chk("ld_addr", req_addr, 16'h00FF);
    chk("ld_done_cyc", done_cyc, 7);
    chk("ld_ready_busy", c_rdy, 0);
    chk("ld_held_ignored", c_rs, 0);

    run("add", 3'b011, 2'd3, 16'h0000, 0, 3, 1'b0);
    chk("add_read", c_rd, 1);
    chk("add_start", c_as, 1);
    chk("add_op", op_s, 2'b00);
    chk("add_wen", c_we, 1);
    chk("add_wb_reg", wb_reg, 2'd3);
    chk("add_done_cyc", done_cyc, 7);

    run("mul", 3'b100, 2'd1, 16'h0000, 0, 1, 1'b0);
    chk("mul_start", c_as, 1);
    chk("mul_op", op_s, 2'b01);
    chk("mul_wb_reg", wb_reg, 2'd1);
    chk("mul_done_cyc", done_cyc, 5);

    run("ld_tmo", 3'b001, 2'd0, 16'h1234, 0, 0, 1'b0);
    chk("tmo_req_cyc", c_req, TIMEOUT);
    chk("tmo_err_cyc", err_cyc, TIMEOUT + 2);
    chk("tmo_no_done", done_cyc, 0);
    chk("tmo_no_load", c_ld, 0);

    run("ld_late", 3'b001, 2'd2, 16'h0042, TIMEOUT, 0, 1'b0);
    chk("late_req_cyc", c_req, TIMEOUT);
    chk("late_done_cyc", done_cyc, TIMEOUT + 3);
    chk("late_no_err", err_cyc, 0);
    chk("late_load", {c_ld[1:0], ld_reg}, {2'd1, 2'd2});

    run("alu_tmo", 3'b011, 2'd1, 16'h0000, 0, 0, 1'b0);
    chk("alu_tmo_err_cyc", err_cyc, TIMEOUT + 3);
    chk("alu_tmo_no_wen", c_we, 0);

    run("illegal", 3'b111, 2'd1, 16'h0000, 0, 0, 1'b0);
    chk("ill_err_cyc", err_cyc, 2);
    chk("ill_no_done", done_cyc, 0);
    chk("ill_no_strobes", c_ld + c_st + c_we + c_rd + c_rs + c_req + c_as, 0);

    chk("strobe_onehot", c_multi, 0);
    chk("store_overlap", c_ovl, 0);

    // Reset in the middle of EXEC
    begin
      bit seen;
      seen = 1'b0;
      instr_valid = 1'b1; instr_op = 3'b011; instr_reg = 2'd3; instr_addr = 16'h0;
      tick();
      instr_valid = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
        if (alu_start) seen = 1'b1;
        else tick();
      end
      chk("mid_start_seen", seen, 1'b1);
      tick();
      #2 reset = 1'b0;
      #1 chk("mid_rst_outs", all_o, '0);
      tick();
      chk("mid_rst_hold", {done, error, instr_ready}, 3'b000);
      reset = 1'b1;
      tick();
      chk("mid_rel", {done, error, instr_ready}, 3'b001);
      tick();
      chk("mid_rel_quiet", {done, error, busy}, 3'b000);
    end

    run("post_nop", 3'b000, 2'd0, 16'h0000, 0, 0, 1'b0);
    chk("post_nop_done_cyc", done_cyc, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vector_controller.md
Name: vector_controller

Overview:
- Instruction sequencer for the 4-entry x 512-bit vector register file.
- Accepts one vector instruction at a time over a valid/ready handshake.
- Sequences the register file strobes (load, store, read, write_enable, random_set) and the matching memory and ALU handshakes.
- Reports completion or error with a one-cycle pulse. Sits between instruction fetch and the register file / ALU / memory interface.

Parameters:
ADDR_W, 16, memory word-address width
TIMEOUT, 16, max cycles to wait for mem_ack or alu_done before aborting (>=2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
instr_valid  in  1  instruction present
instr_ready  out  1  controller can accept an instruction
instr_op  in  3  opcode: 000 NOP, 001 LOAD, 010 STORE, 011 ADD, 100 MUL, 101 RSET, others illegal
instr_reg  in  2  destination/source vector register
instr_addr  in  ADDR_W  memory address for LOAD/STORE
mem_req  out  1  memory request
mem_we  out  1  1 = write (STORE), 0 = read (LOAD)
mem_addr  out  ADDR_W  latched instr_addr
mem_ack  in  1  memory completion, single-cycle
alu_start  out  1  one-cycle ALU start pulse
alu_op  out  2  00 ADD, 01 MUL
alu_done  in  1  ALU result valid, single-cycle
rf_load  out  1  register file load strobe
rf_store  out  1  register file store strobe
rf_write_enable  out  1  ALU result writeback strobe
rf_read  out  1  operand read strobe
rf_random_set  out  1  random-set strobe
rf_load_addr_reg  out  2  load target register
rf_store_addr_reg  out  2  store source register
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle completion pulse
error  out  1  one-cycle pulse on illegal opcode or timeout

Behaviour:
- All outputs are registered, computed from next_state, so each is valid in the cycle the FSM occupies the state.
- While reset is low: state IDLE, timer 0, every output 0 (including instr_ready). On the first edge after release, instr_ready goes to 1.
- IDLE:
  - instr_ready=1.
  - On instr_valid & instr_ready at an edge: latch op/reg/addr and go to DECODE.
  - instr_ready=0 in every other state; instr_valid there is ignored, not queued.
- DECODE (1 cycle) routes by opcode:
  - NOP -> DONE; LOAD -> MEM_RD; STORE -> ST_RF; ADD/MUL -> RD_OPS; RSET -> RSET; illegal -> ERR.
- MEM_RD:
  - mem_req=1, mem_we=0, mem_addr=latched address.
  - On mem_ack -> LD_WB.
- LD_WB: rf_load=1, rf_load_addr_reg=reg for one cycle -> DONE.
- ST_RF: rf_store=1, rf_store_addr_reg=reg for one cycle -> MEM_WR.
- MEM_WR:
  - rf_store stays 1 so store_data is stable; mem_req=1, mem_we=1.
  - On mem_ack -> DONE.
- RD_OPS: rf_read=1 for one cycle -> EXEC.
- EXEC:
  - alu_start=1 in the first cycle only; alu_op=op[0]^1 (ADD=00, MUL=01).
  - On alu_done -> WB.
- WB: rf_write_enable=1, rf_load_addr_reg=reg for one cycle -> DONE.
- RSET: rf_random_set=1 for one cycle -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- ERR: error=1 for one cycle -> IDLE; the register file is untouched.
- Timer:
  - Cleared on entry to MEM_RD, MEM_WR and EXEC; increments each cycle in those states.
  - At count TIMEOUT-1 with no ack/done -> ERR, and mem_req/rf_store drop in that same transition.
  - Ack/done arriving in the timeout cycle wins: normal path, no error.
- Ack/done arriving in any non-wait state is ignored.
- At most one of rf_load, rf_write_enable, rf_read, rf_random_set is high per cycle. rf_store only overlaps mem_req during MEM_WR.
- Latency, accept edge to done high: NOP 2 cycles; RSET 3; LOAD 3+memory wait; STORE 3+memory wait; ADD/MUL 4+ALU wait.
- Reset asserted mid-operation aborts immediately: no done, no error, strobes drop asynchronously.

Decomposition:
- vector_ctrl_pkg: opcode constants, state enum, ALU op codes.
- Sub-module vector_wait_timer: clear/enable/expire counter parameterised by TIMEOUT. Everything else stays in one module.

Test Plan:
- Reset low 3 cycles, then release -> all outputs 0 during reset; instr_ready=1 one edge after release.
- RSET reg=2 -> rf_random_set one cycle, done 3 cycles after accept; STORE reg=2, addr=0x0010, mem_ack after 2 cycles -> rf_store held 2 cycles with mem_we=1, mem_addr=0x0010, then done.
- LOAD reg=1, addr=0x00FF, mem_ack 4 cycles after mem_req -> rf_load with rf_load_addr_reg=1 for exactly one cycle, then done; instr_valid held during busy -> ignored.
- ADD reg=3, alu_done 3 cycles after start -> rf_read, one alu_start pulse with alu_op=00, rf_write_enable with address 3, done; repeat with MUL -> alu_op=01.
- LOAD with mem_ack never asserted (TIMEOUT=16) -> mem_req high 16 cycles, then error pulse and no rf_load. mem_ack in cycle 16 -> normal completion. Opcode 111 -> error 2 cycles after accept.
- Reset low during EXEC -> all strobes 0 immediately; no done or error after release; next NOP completes normally.
